// File: rtl/mure_block_scheduler_pkg.sv
// Shared types and constants for the block scheduler: block record, scheduler
// FSM states and trap itype encodings.
package mure_block_scheduler_pkg;

    localparam int unsigned IRETIRE_LEN = 32;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT = ITYPE_LEN'(2);

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        iaddr;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
    } block_s;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    // Exceptions and interrupts are the only blocks that carry cause/tval.
    function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

endpackage

// File: rtl/mure_block_scheduler_if.sv
// Encoder-side block stream of the scheduler (head block plus handshake).
interface mure_block_scheduler_if;
    import mure_block_scheduler_pkg::*;

    // valid_o/ready_i: a block transfers on every cycle where both are high;
    // once valid_o is high the head fields hold steady until that transfer.
    logic                   valid_o;
    logic                   ready_i;
    logic [IRETIRE_LEN-1:0] iretire_o;
    logic                   ilastsize_o;
    logic [ITYPE_LEN-1:0]   itype_o;
    logic [XLEN-1:0]        iaddr_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;
    logic [PRIV_LEN-1:0]    priv_o;

    modport master (
        output valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
        output ready_i
    );

endinterface

// File: rtl/mure_block_queue.sv
// Circular block buffer: up to N compacted writes and one read per cycle,
// with an occupancy count wide enough to represent a full queue.
module mure_block_queue
    import mure_block_scheduler_pkg::*;
#(
    parameter int N     = 1,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [N-1:0]     wr_valid_i,
    input  block_s [N-1:0]   wr_blk_i,
    input  logic [CW-1:0]    wr_num_i,
    input  logic             rd_en_i,
    output block_s           head_o,
    output logic [CW-1:0]    count_o,
    output logic [CW-1:0]    count_next_o
);

    block_s           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    block_s [N-1:0]   slot;

    // Slot k receives the k-th valid lane in ascending lane order.
    always_comb begin
        int rank;
        slot = '0;
        rank = 0;
        for (int l = 0; l < N; l++) begin
            if (wr_valid_i[l]) begin
                for (int k = 0; k < N; k++) begin
                    if (k == rank) slot[k] = wr_blk_i[l];
                end
                rank = rank + 1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + wr_num_i[AW-1:0];
        if (rd_en_i) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (wr_en_i ? wr_num_i : '0) - CW'(rd_en_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en_i) begin
                for (int k = 0; k < N; k++) begin
                    if (CW'(k) < wr_num_i) mem_q[wr_ptr_q + AW'(k)] <= slot[k];
                end
            end
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/mure_block_scheduler.sv
// Block scheduler: buffers retirement groups and streams one block per cycle.
// Define MURE_SCHED_STATS_EN to add saturating emitted/dropped block counters.
module mure_block_scheduler
    import mure_block_scheduler_pkg::*;
#(
    parameter int N            = 1,
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = N,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N-1:0]                   valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0]  iretire_i,
    input  logic [N-1:0]                   ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]    itype_i,
    input  logic [N-1:0][XLEN-1:0]         iaddr_i,
    input  logic [CAUSE_LEN-1:0]           cause_i,
    input  logic [XLEN-1:0]                tval_i,
    input  logic [PRIV_LEN-1:0]            priv_i,
    mure_block_scheduler_if.master         enc,
    output logic                           stall_o,
    input  logic                           flush_i,
    output logic                           flush_done_o,
    output logic                           overflow_o,
    input  logic                           clear_ovf_i,
    output sched_state_e                   state_o
`ifdef MURE_SCHED_STATS_EN
   ,output logic [31:0]                    emitted_cnt_o,
    output logic [31:0]                    dropped_cnt_o
`endif
);

    sched_state_e   state_q, state_d;
    logic           stall_q, stall_d;
    logic           flush_done_q;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  nv;
    logic [CW-1:0]  count, count_next;
    logic           accept, drop, pop;
    block_s [N-1:0] lane_blk;
    block_s         head;

    always_comb begin
        nv = '0;
        for (int l = 0; l < N; l++) nv = nv + CW'(valid_i[l]);
    end

    assign accept = (nv != '0) && (nv <= CW'(DEPTH) - count) && (state_q == RUN);
    assign drop   = (nv != '0) && !accept;
    assign pop    = enc.valid_o && enc.ready_i;

    // Only the lowest valid lane may carry trap information.
    always_comb begin
        logic first;
        first = 1'b1;
        for (int l = 0; l < N; l++) begin
            lane_blk[l].iretire   = iretire_i[l];
            lane_blk[l].ilastsize = ilastsize_i[l];
            lane_blk[l].itype     = itype_i[l];
            lane_blk[l].iaddr     = iaddr_i[l];
            lane_blk[l].priv      = priv_i;
            lane_blk[l].cause     = '0;
            lane_blk[l].tval      = '0;
            if (valid_i[l] && first && is_trap(itype_i[l])) begin
                lane_blk[l].cause = cause_i;
                lane_blk[l].tval  = tval_i;
            end
            if (valid_i[l]) first = 1'b0;
        end
    end

    mure_block_queue #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_en_i      (accept),
        .wr_valid_i   (valid_i),
        .wr_blk_i     (lane_blk),
        .wr_num_i     (nv),
        .rd_en_i      (pop),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i) state_d = DRAIN;
            DRAIN:   if (count == '0) state_d = DONE;
            DONE:    state_d = flush_i ? DRAIN : RUN;
            default: state_d = RUN;
        endcase
    end

    assign stall_d = (CW'(DEPTH) - count_next < CW'(STALL_MARGIN)) || (state_d != RUN);
    assign ovf_d   = drop ? 1'b1 : (clear_ovf_i ? 1'b0 : ovf_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            stall_q      <= 1'b0;
            flush_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            flush_done_q <= (state_d == DONE);
            ovf_q        <= ovf_d;
        end
    end

    assign enc.valid_o     = (count != '0);
    assign enc.iretire_o   = head.iretire;
    assign enc.ilastsize_o = head.ilastsize;
    assign enc.itype_o     = head.itype;
    assign enc.iaddr_o     = head.iaddr;
    assign enc.cause_o     = head.cause;
    assign enc.tval_o      = head.tval;
    assign enc.priv_o      = head.priv;

    assign stall_o      = stall_q;
    assign flush_done_o = flush_done_q;
    assign overflow_o   = ovf_q;
    assign state_o      = state_q;

`ifdef MURE_SCHED_STATS_EN
    logic [31:0] emitted_q, dropped_q;
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, dropped_q} + 33'(nv);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            emitted_q <= '0;
            dropped_q <= '0;
        end else begin
            if (pop && (emitted_q != '1)) emitted_q <= emitted_q + 32'd1;
            if (drop) dropped_q <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign emitted_cnt_o = emitted_q;
    assign dropped_cnt_o = dropped_q;
`endif

endmodule

// File: tb/tb_mure_block_scheduler.sv
// Directed bench for the block scheduler (N=2, DEPTH=8) with a queue scoreboard.
module tb_mure_block_scheduler;
  import mure_block_scheduler_pkg::*;

  localparam int W = 72;

  logic             clk_i;
  logic             rst_i;
  logic [1:0]       valid_i;
  logic [1:0][31:0] iretire_i;
  logic [1:0]       ilastsize_i;
  logic [1:0][2:0]  itype_i;
  logic [1:0][31:0] iaddr_i;
  logic [4:0]       cause_i;
  logic [31:0]      tval_i;
  logic [1:0]       priv_i;
  logic             stall_o;
  logic             flush_i;
  logic             flush_done_o;
  logic             overflow_o;
  logic             clear_ovf_i;
  sched_state_e     state_o;
`ifdef MURE_SCHED_STATS_EN
  logic [31:0]      emitted_cnt_o;
  logic [31:0]      dropped_cnt_o;
`endif

  mure_block_scheduler_if enc();

  mure_block_scheduler #(
    .N            (2),
    .DEPTH        (8),
    .STALL_MARGIN (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .iretire_i    (iretire_i),
    .ilastsize_i  (ilastsize_i),
    .itype_i      (itype_i),
    .iaddr_i      (iaddr_i),
    .cause_i      (cause_i),
    .tval_i       (tval_i),
    .priv_i       (priv_i),
    .enc          (enc),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .overflow_o   (overflow_o),
    .clear_ovf_i  (clear_ovf_i),
    .state_o      (state_o)
`ifdef MURE_SCHED_STATS_EN
   ,.emitted_cnt_o (emitted_cnt_o),
    .dropped_cnt_o (dropped_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [31:0] a, input logic [4:0] c,
                                            input logic [31:0] t, input logic [2:0] it);
    return {a, c, t, it};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_grp(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [2:0] t0, input logic [2:0] t1,
                         input logic [4:0] c, input logic [31:0] tv);
    valid_i    = v;
    iaddr_i[0] = a0;
    iaddr_i[1] = a1;
    itype_i[0] = t0;
    itype_i[1] = t1;
    cause_i    = c;
    tval_i     = tv;
  endtask

  task automatic drive_grp(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [2:0] t0, input logic [2:0] t1,
                           input logic [4:0] c, input logic [31:0] tv);
    set_grp(v, a0, a1, t0, t1, c, tv);
    step();
    valid_i = '0;
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i && enc.valid_o && enc.ready_i) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {enc.iaddr_o, enc.cause_o, enc.tval_o, enc.itype_o}, '0);
      end else begin
        check("pop_block", {enc.iaddr_o, enc.cause_o, enc.tval_o, enc.itype_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst_i       = 1'b1;
    valid_i     = '0;
    iretire_i   = {32'h0000_0004, 32'h0000_0002};
    ilastsize_i = 2'b00;
    itype_i     = '0;
    iaddr_i     = '0;
    cause_i     = '0;
    tval_i      = '0;
    priv_i      = 2'd3;
    flush_i     = 1'b0;
    clear_ovf_i = 1'b0;
    enc.ready_i = 1'b0;
    step();
    step();
    check("rst_valid", W'(enc.valid_o), W'(0));
    check("rst_stall", W'(stall_o), W'(0));
    check("rst_ovf", W'(overflow_o), W'(0));
    check("rst_flush_done", W'(flush_done_o), W'(0));
    check("rst_iaddr", W'(enc.iaddr_o), W'(0));
    rst_i = 1'b0;
    step();
    check("rst_state", W'(state_o), W'(RUN));

    // two lanes, streamed in lane order with one cycle latency
    enc.ready_i = 1'b1;
    set_grp(2'b11, 32'h100, 32'h200, 3'd0, 3'd0, 5'd0, 32'd0);
    exp_q.push_back(exp_word(32'h100, 5'd0, 32'd0, 3'd0));
    exp_q.push_back(exp_word(32'h200, 5'd0, 32'd0, 3'd0));
    check("no_bypass", W'(enc.valid_o), W'(0));
    step();
    valid_i = '0;
    check("lat_valid", W'(enc.valid_o), W'(1));
    check("lat_iaddr", W'(enc.iaddr_o), W'(32'h100));
    step();
    check("second_iaddr", W'(enc.iaddr_o), W'(32'h200));
    step();
    check("drained_valid", W'(enc.valid_o), W'(0));

    // upper lane only is compacted into one entry
    drive_grp(2'b10, 32'hdead_0000, 32'h300, 3'd0, 3'd0, 5'd0, 32'd0);
    exp_q.push_back(exp_word(32'h300, 5'd0, 32'd0, 3'd0));
    check("compact_valid", W'(enc.valid_o), W'(1));
    check("compact_iaddr", W'(enc.iaddr_o), W'(32'h300));
    step();
    check("compact_single", W'(enc.valid_o), W'(0));

    // fill to DEPTH with the encoder blocked
    enc.ready_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(exp_word(32'h400 + 32'(g * 16), 5'd0, 32'd0, 3'd0));
      exp_q.push_back(exp_word(32'h408 + 32'(g * 16), 5'd0, 32'd0, 3'd0));
      drive_grp(2'b11, 32'h400 + 32'(g * 16), 32'h408 + 32'(g * 16), 3'd0, 3'd0, 5'd0, 32'd0);
      if (g == 2) check("stall_at_6", W'(stall_o), W'(0));
    end
    check("stall_at_8", W'(stall_o), W'(1));
    check("full_ovf_clear", W'(overflow_o), W'(0));
    drive_grp(2'b11, 32'hbad0, 32'hbad8, 3'd0, 3'd0, 5'd0, 32'd0);
    check("drop_ovf", W'(overflow_o), W'(1));
    check("drop_head_stable", W'(enc.iaddr_o), W'(32'h400));
    clear_ovf_i = 1'b1;
    step();
    clear_ovf_i = 1'b0;
    check("ovf_cleared", W'(overflow_o), W'(0));
    set_grp(2'b01, 32'hbae0, 32'h0, 3'd0, 3'd0, 5'd0, 32'd0);
    clear_ovf_i = 1'b1;
    step();
    valid_i = '0;
    clear_ovf_i = 1'b0;
    check("ovf_set_wins", W'(overflow_o), W'(1));
    clear_ovf_i = 1'b1;
    step();
    clear_ovf_i = 1'b0;
    check("ovf_cleared2", W'(overflow_o), W'(0));
    enc.ready_i = 1'b1;
    repeat (10) step();
    check("full_drained", W'(enc.valid_o), W'(0));
    check("full_unstall", W'(stall_o), W'(0));

    // trap fields travel only with the lowest valid lane
    enc.ready_i = 1'b0;
    drive_grp(2'b01, 32'h500, 32'h0, 3'd1, 3'd0, 5'h2, 32'hdead);
    exp_q.push_back(exp_word(32'h500, 5'h2, 32'hdead, 3'd1));
    check("exc_cause", W'(enc.cause_o), W'(5'h2));
    check("exc_tval", W'(enc.tval_o), W'(32'hdead));
    drive_grp(2'b01, 32'h504, 32'h0, 3'd0, 3'd0, 5'h3, 32'hbeef);
    exp_q.push_back(exp_word(32'h504, 5'd0, 32'd0, 3'd0));
    check("hold_iaddr", W'(enc.iaddr_o), W'(32'h500));
    drive_grp(2'b11, 32'h508, 32'h50c, 3'd0, 3'd2, 5'h5, 32'h55);
    exp_q.push_back(exp_word(32'h508, 5'd0, 32'd0, 3'd0));
    exp_q.push_back(exp_word(32'h50c, 5'd0, 32'd0, 3'd2));
    drive_grp(2'b10, 32'h0, 32'h510, 3'd1, 3'd2, 5'h7, 32'h77);
    exp_q.push_back(exp_word(32'h510, 5'h7, 32'h77, 3'd2));
    enc.ready_i = 1'b1;
    repeat (7) step();

    // flush: the group alongside the request lands, later groups drop
    enc.ready_i = 1'b0;
    drive_grp(2'b11, 32'h600, 32'h608, 3'd0, 3'd0, 5'd0, 32'd0);
    exp_q.push_back(exp_word(32'h600, 5'd0, 32'd0, 3'd0));
    exp_q.push_back(exp_word(32'h608, 5'd0, 32'd0, 3'd0));
    drive_grp(2'b01, 32'h610, 32'h0, 3'd0, 3'd0, 5'd0, 32'd0);
    exp_q.push_back(exp_word(32'h610, 5'd0, 32'd0, 3'd0));
    set_grp(2'b01, 32'h618, 32'h0, 3'd0, 3'd0, 5'd0, 32'd0);
    exp_q.push_back(exp_word(32'h618, 5'd0, 32'd0, 3'd0));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = '0;
    check("drain_stall", W'(stall_o), W'(1));
    check("drain_state", W'(state_o), W'(DRAIN));
    enc.ready_i = 1'b1;
    drive_grp(2'b11, 32'hbbb0, 32'hbbb8, 3'd0, 3'd0, 5'd0, 32'd0);
    check("drain_drop_ovf", W'(overflow_o), W'(1));
    n = 0;
    while (!flush_done_o && n < 30) begin
      step();
      n++;
    end
    check("flush_done_seen", W'(flush_done_o), W'(1));
    check("done_stall", W'(stall_o), W'(1));
    check("done_empty", W'(enc.valid_o), W'(0));
    step();
    check("flush_done_pulse", W'(flush_done_o), W'(0));
    check("run_unstall", W'(stall_o), W'(0));
    check("run_state", W'(state_o), W'(RUN));

    // asynchronous reset with blocks queued and overflow still set
    enc.ready_i = 1'b0;
    drive_grp(2'b11, 32'h800, 32'h808, 3'd0, 3'd0, 5'd0, 32'd0);
    drive_grp(2'b11, 32'h810, 32'h818, 3'd0, 3'd0, 5'd0, 32'd0);
    drive_grp(2'b01, 32'h820, 32'h0, 3'd0, 3'd0, 5'd0, 32'd0);
    check("pre_rst_valid", W'(enc.valid_o), W'(1));
    check("pre_rst_ovf", W'(overflow_o), W'(1));
    #3;
    rst_i = 1'b1;
    #1;
    check("async_valid", W'(enc.valid_o), W'(0));
    check("async_stall", W'(stall_o), W'(0));
    check("async_ovf", W'(overflow_o), W'(0));
    step();
    step();
    rst_i = 1'b0;
    enc.ready_i = 1'b1;
    step();
    check("post_rst_empty", W'(enc.valid_o), W'(0));
    drive_grp(2'b01, 32'h700, 32'h0, 3'd0, 3'd0, 5'd0, 32'd0);
    exp_q.push_back(exp_word(32'h700, 5'd0, 32'd0, 3'd0));
    check("post_rst_iaddr", W'(enc.iaddr_o), W'(32'h700));
    repeat (3) step();

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
